mca_sequencer: RTL and testbench
================================

MCA_SEQUENCER -- requirements
Module: mca_sequencer

Interface
REQ-001 SHALL have parameter WIDTH_COEFFICIENT, default 32, meaning operand/result width.
REQ-002 SHALL have parameter NUM_ADDITIONS, default 16, range 1..16, meaning number of operands/control bits per result.
REQ-003 SHALL have parameter DOWNSAMPLE, default 4, range 1..256, meaning number of accepted samples between results.
REQ-004 SHALL have parameter MCA_LATENCY, default 17, meaning cycles from start to valid mca res.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ce, input, 1 bit: global clock enable, driven unchanged onto mca_enable.
REQ-008 SHALL have port s_valid, input, 1 bit: s_bit is valid this cycle.
REQ-009 SHALL have port s_bit, input, 1 bit: incoming control bit.
REQ-010 SHALL have ports coef_we (input, 1), coef_addr (input, 4) and coef_data (input, WIDTH_COEFFICIENT, signed): coefficient bank write port.
REQ-011 SHALL have port mca_start, output, 1 bit: start pulse to the adder.
REQ-012 SHALL have port mca_enable, output, 1 bit: enable to the adder.
REQ-013 SHALL have port mca_operands, output, NUM_ADDITIONS x WIDTH_COEFFICIENT signed: coefficient bank contents.
REQ-014 SHALL have port mca_s_values, output, NUM_ADDITIONS x 1: snapshot of control bits.
REQ-015 SHALL have port mca_res, input, WIDTH_COEFFICIENT signed: adder result.
REQ-016 SHALL have port out_valid, output, 1 bit: one-cycle strobe marking out_data valid.
REQ-017 SHALL have port out_data, output, WIDTH_COEFFICIENT signed: captured result.
REQ-018 SHALL have port overrun, output, 1 bit: sticky flag indicating a dropped trigger.

Function
REQ-019 SHALL advance all state only in cycles where ce=1; with ce=0, every register SHALL hold and out_valid/mca_start SHALL be 0.
REQ-020 SHALL shift s_bit into index 0 of an NUM_ADDITIONS-bit shift register on each ce & s_valid, moving older bits toward higher indices.
REQ-021 SHALL count accepted samples in a fill counter saturating at NUM_ADDITIONS, and in a phase counter that wraps from DOWNSAMPLE-1 to 0.
REQ-022 SHALL raise a trigger when the phase counter wraps and the fill counter has saturated, with the fill counter evaluated after the current sample is included.
REQ-023 SHALL use a state machine with states SEQ_IDLE, SEQ_START, SEQ_WAIT and SEQ_CAPTURE.
REQ-024 In SEQ_IDLE, a trigger SHALL copy the post-shift register into the snapshot and move the FSM to SEQ_START.
REQ-025 In SEQ_START, mca_start SHALL be 1 for exactly one cycle, a wait counter SHALL load 0, and the FSM SHALL move to SEQ_WAIT.
REQ-026 In SEQ_WAIT, the wait counter SHALL increment each cycle, and the FSM SHALL move to SEQ_CAPTURE when the counter equals MCA_LATENCY-1.
REQ-027 In SEQ_CAPTURE, out_data SHALL load mca_res, out_valid SHALL pulse for one cycle, and the FSM SHALL return to SEQ_IDLE.
REQ-028 The latency from the mca_start cycle to the out_valid cycle SHALL be MCA_LATENCY+1 ce-cycles.
REQ-029 A trigger arriving in any state other than SEQ_IDLE SHALL be dropped and SHALL set overrun, which stays set until reset; the shift register SHALL keep shifting.
REQ-030 mca_s_values SHALL change only in SEQ_IDLE.
REQ-031 coef_we SHALL write coefficient[coef_addr] in any state; writes with coef_addr >= NUM_ADDITIONS SHALL be ignored.
REQ-032 If a write and a trigger occur in the same cycle, the write SHALL take effect and the snapshot SHALL be taken as normal.
REQ-033 out_data SHALL hold its value between out_valid strobes.

Reset
REQ-034 While rst=1 at a clock edge, the FSM SHALL go to SEQ_IDLE and all counters, the shift register, the snapshot, the coefficients, out_data, out_valid, mca_start and overrun SHALL clear to 0, regardless of ce.
REQ-035 Reset mid-computation SHALL abandon the computation with no out_valid; the bench SHALL also reset the adder.

Structure
REQ-036 The state enum seq_state_e SHALL live in FIR_pkg, next to the adder's state type.
REQ-037 The default MCA_LATENCY constant SHALL live in FIR_pkg.
REQ-038 The block SHALL be flat, with no sub-module; the adder is instantiated beside it at top level.

Verification
REQ-039 Reset, program coefficients k to k+1, send 16 samples of 1 -> exactly one mca_start, and 18 cycles later out_valid with out_data=136.
REQ-040 Alternating bits 1,0,... (last=0), coefficients all 5 -> mca_s_values[0]=0, out_data=0, next result every 4 samples.
REQ-041 s_valid held high continuously, DOWNSAMPLE=4 -> overrun=1 after the second trigger, and out_valid strobes only for accepted triggers.
REQ-042 ce toggled 0/1 every cycle during SEQ_WAIT -> out_valid 18 ce-cycles after start, with a correct value.
REQ-043 rst pulsed at wait count 8 -> no out_valid, all outputs 0, and the next 16 samples start a fresh fill.
REQ-044 coef_we at coef_addr=15 with a trigger in the same cycle -> the result uses the new coefficient, and a write to an out-of-range address is ignored (NUM_ADDITIONS=8).

Source files
------------

// File: rtl/mca_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// FIR_pkg
// Shared types and constants for the multiply-conditional-add (MCA) datapath:
// the sequencer's state type, the adder's state type and the default adder
// latency. Imported by the sequencer, its interface and the bench.
// -----------------------------------------------------------------------------
package FIR_pkg;

    // Adder pipeline depth: cycles from mca_start to a valid mca_res.
    localparam int DEFAULT_MCA_LATENCY = 17;

    // Coefficient bank address width (bank holds at most 16 entries).
    localparam int COEF_ADDR_W = 4;

    // State of the conditional adder instantiated beside the sequencer.
    typedef enum logic [1:0] {
        MCA_IDLE,
        MCA_BUSY
    } mca_state_e;

    // Sequencer control states.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_START,
        SEQ_WAIT,
        SEQ_CAPTURE
    } seq_state_e;

endpackage

// File: rtl/mca_sequencer_if.sv
// -----------------------------------------------------------------------------
// mca_sequencer_if
// Bundles every sequencer signal except clk/rst:
//   ce, s_valid, s_bit                 - clock enable and serial control bits
//   coef_we, coef_addr, coef_data      - coefficient bank write port
//   mca_start, mca_enable,
//   mca_operands, mca_s_values, mca_res - link to the conditional adder
//   out_valid, out_data, overrun       - captured result and drop flag
// Modport master is the sequencer side, slave is the environment side.
// -----------------------------------------------------------------------------
interface mca_sequencer_if #(
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int NUM_ADDITIONS     = 16
);
    logic                                ce;
    logic                                s_valid;
    logic                                s_bit;
    logic                                coef_we;
    logic [FIR_pkg::COEF_ADDR_W-1:0]     coef_addr;
    logic signed [WIDTH_COEFFICIENT-1:0] coef_data;
    logic                                mca_start;
    logic                                mca_enable;
    logic signed [WIDTH_COEFFICIENT-1:0] mca_operands [NUM_ADDITIONS];
    logic [NUM_ADDITIONS-1:0]            mca_s_values;
    logic signed [WIDTH_COEFFICIENT-1:0] mca_res;
    logic                                out_valid;
    logic signed [WIDTH_COEFFICIENT-1:0] out_data;
    logic                                overrun;

    modport master (
        input  ce, s_valid, s_bit, coef_we, coef_addr, coef_data, mca_res,
        output mca_start, mca_enable, mca_operands, mca_s_values,
               out_valid, out_data, overrun
    );

    modport slave (
        output ce, s_valid, s_bit, coef_we, coef_addr, coef_data, mca_res,
        input  mca_start, mca_enable, mca_operands, mca_s_values,
               out_valid, out_data, overrun
    );
endinterface

// File: rtl/mca_sequencer.sv
// -----------------------------------------------------------------------------
// mca_sequencer
// Collects serial control bits into a shift register, and every DOWNSAMPLE
// accepted samples (once the register has filled) snapshots the bits, starts
// the external conditional adder, waits out its latency and captures the sum.
// Ports:
//   clk  - single rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mca_sequencer_if.master (sample input, coefficient writes,
//          adder link, result/overrun outputs)
// -----------------------------------------------------------------------------
module mca_sequencer
    import FIR_pkg::*;
#(
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int NUM_ADDITIONS     = 16,
    parameter int DOWNSAMPLE        = 4,
    parameter int MCA_LATENCY       = DEFAULT_MCA_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    mca_sequencer_if.master   bus
);

    localparam int FILL_W  = $clog2(NUM_ADDITIONS + 1);
    localparam int PHASE_W = (DOWNSAMPLE > 1) ? $clog2(DOWNSAMPLE) : 1;
    localparam int WAIT_W  = (MCA_LATENCY > 1) ? $clog2(MCA_LATENCY) : 1;

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(NUM_ADDITIONS);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DOWNSAMPLE - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MCA_LATENCY - 1);

    seq_state_e                          state_reg, state_next;
    logic [FILL_W-1:0]                   fill_reg, fill_next;
    logic [PHASE_W-1:0]                  phase_reg, phase_next;
    logic [WAIT_W-1:0]                   wait_reg, wait_next;
    logic [NUM_ADDITIONS-1:0]            shift_reg, shift_in, shift_post;
    logic [NUM_ADDITIONS-1:0]            snap_reg, snap_next;
    logic signed [WIDTH_COEFFICIENT-1:0] out_data_reg, out_data_next;
    logic                                overrun_reg, overrun_next;
    logic signed [WIDTH_COEFFICIENT-1:0] coef_reg [NUM_ADDITIONS];

    logic accept;
    logic trigger;
    logic start_c;
    logic capture_c;

    assign accept = bus.ce & bus.s_valid;

    // Newest bit enters at index 0, older bits move toward the top.
    generate
        if (NUM_ADDITIONS > 1) begin : g_shift
            assign shift_in = {shift_reg[NUM_ADDITIONS-2:0], bus.s_bit};
        end else begin : g_shift_single
            assign shift_in = bus.s_bit;
        end
    endgenerate

    // Sample bookkeeping: shift register, fill and phase counters.
    always_comb begin
        shift_post = shift_reg;
        fill_next  = fill_reg;
        phase_next = phase_reg;
        if (accept) begin
            shift_post = shift_in;
            fill_next  = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
            phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
        end
    end

    // The fill test uses the post-increment count so the sample that
    // completes the register can itself fire the first trigger.
    assign trigger = accept && (phase_reg == PHASE_LAST) && (fill_next == FILL_FULL);

    // Control FSM: next state and per-state actions.
    always_comb begin
        state_next    = state_reg;
        wait_next     = wait_reg;
        snap_next     = snap_reg;
        out_data_next = out_data_reg;
        overrun_next  = overrun_reg;
        start_c       = 1'b0;
        capture_c     = 1'b0;

        case (state_reg)
            SEQ_IDLE: begin
                if (trigger) begin
                    snap_next  = shift_post;
                    state_next = SEQ_START;
                end
            end
            SEQ_START: begin
                start_c    = 1'b1;
                wait_next  = '0;
                state_next = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                wait_next = wait_reg + 1'b1;
                if (wait_reg == WAIT_LAST) begin
                    // mca_res is latched on the edge that enters CAPTURE, so
                    // out_data is already valid while out_valid is high.
                    out_data_next = bus.mca_res;
                    state_next    = SEQ_CAPTURE;
                end
            end
            SEQ_CAPTURE: begin
                capture_c  = 1'b1;
                state_next = SEQ_IDLE;
            end
            default: state_next = SEQ_IDLE;
        endcase

        // A trigger while busy is lost; remember that until reset.
        if (trigger && (state_reg != SEQ_IDLE)) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= SEQ_IDLE;
            fill_reg     <= '0;
            phase_reg    <= '0;
            wait_reg     <= '0;
            shift_reg    <= '0;
            snap_reg     <= '0;
            out_data_reg <= '0;
            overrun_reg  <= 1'b0;
        end else if (bus.ce) begin
            state_reg    <= state_next;
            fill_reg     <= fill_next;
            phase_reg    <= phase_next;
            wait_reg     <= wait_next;
            shift_reg    <= shift_post;
            snap_reg     <= snap_next;
            out_data_reg <= out_data_next;
            overrun_reg  <= overrun_next;
        end
    end

    // Coefficient bank: one register per operand; addresses beyond the bank
    // match no entry and are therefore ignored.
    generate
        for (genvar gi = 0; gi < NUM_ADDITIONS; gi++) begin : g_coef
            always_ff @(posedge clk) begin
                if (rst) begin
                    coef_reg[gi] <= '0;
                end else if (bus.ce && bus.coef_we &&
                             (bus.coef_addr == COEF_ADDR_W'(gi))) begin
                    coef_reg[gi] <= bus.coef_data;
                end
            end
            assign bus.mca_operands[gi] = coef_reg[gi];
        end
    endgenerate

    // Strobes are masked by ce so a stalled cycle never shows a pulse.
    assign bus.mca_start    = start_c & bus.ce;
    assign bus.out_valid    = capture_c & bus.ce;
    assign bus.mca_enable   = bus.ce;
    assign bus.mca_s_values = snap_reg;
    assign bus.out_data     = out_data_reg;
    assign bus.overrun      = overrun_reg;

endmodule

// File: tb/tb_mca_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mca_sequencer
// Directed bench for mca_sequencer: a 16-operand instance (DOWNSAMPLE 4,
// latency 17) and an 8-operand instance for out-of-range coefficient writes.
// The adder beside each instance adds the operand for a 1 bit and subtracts
// it for a 0 bit; it latches the sum on mca_start and clears on reset.
// -----------------------------------------------------------------------------
module tb_mca_sequencer;
    import FIR_pkg::*;

    localparam int W = 32;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst8 = 1'b1;
    always #5 clk = ~clk;

    mca_sequencer_if #(.WIDTH_COEFFICIENT(W), .NUM_ADDITIONS(16)) bus  ();
    mca_sequencer_if #(.WIDTH_COEFFICIENT(W), .NUM_ADDITIONS(8))  bus8 ();

    mca_sequencer #(
        .WIDTH_COEFFICIENT(W), .NUM_ADDITIONS(16), .DOWNSAMPLE(4), .MCA_LATENCY(17)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    mca_sequencer #(
        .WIDTH_COEFFICIENT(W), .NUM_ADDITIONS(8), .DOWNSAMPLE(4), .MCA_LATENCY(17)
    ) dut8 (
        .clk(clk), .rst(rst8), .bus(bus8)
    );

    // Conditional adder models.
    logic signed [W-1:0] acc16, acc8, res16, res8;

    always_comb begin
        acc16 = '0;
        for (int i = 0; i < 16; i++) begin
            if (bus.mca_s_values[i]) acc16 = acc16 + bus.mca_operands[i];
            else                     acc16 = acc16 - bus.mca_operands[i];
        end
    end

    always_comb begin
        acc8 = '0;
        for (int i = 0; i < 8; i++) begin
            if (bus8.mca_s_values[i]) acc8 = acc8 + bus8.mca_operands[i];
            else                      acc8 = acc8 - bus8.mca_operands[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) res16 <= '0;
        else if (bus.mca_enable && bus.mca_start) res16 <= acc16;
    end

    always_ff @(posedge clk) begin
        if (rst8) res8 <= '0;
        else if (bus8.mca_enable && bus8.mca_start) res8 <= acc8;
    end

    assign bus.mca_res  = res16;
    assign bus8.mca_res = res8;

    // Event monitors, sampled mid-cycle.
    int ce_cnt = 0, start_cnt = 0, start_at = 0, valid_cnt = 0, valid_at = 0, bad_cnt = 0;
    int start8_cnt = 0, valid8_cnt = 0;
    logic signed [W-1:0] last_data = '0, last8 = '0;

    always @(negedge clk) begin
        if (rst) begin
            start_cnt = 0;
            valid_cnt = 0;
        end else if (bus.ce) begin
            ce_cnt++;
            if (bus.mca_start) begin start_cnt++; start_at = ce_cnt; end
            if (bus.out_valid) begin valid_cnt++; valid_at = ce_cnt; last_data = bus.out_data; end
        end else if (bus.mca_start || bus.out_valid) begin
            bad_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst8) begin
            start8_cnt = 0;
            valid8_cnt = 0;
        end else if (bus8.ce) begin
            if (bus8.mca_start) start8_cnt++;
            if (bus8.out_valid) begin valid8_cnt++; last8 = bus8.out_data; end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Coefficient k = k+1 for all 16 entries.
    task automatic prog_ramp();
        for (int k = 0; k < 16; k++) begin
            bus.coef_we = 1'b1; bus.coef_addr = 4'(k); bus.coef_data = W'(k + 1);
            tick();
        end
        bus.coef_we = 1'b0;
    endtask

    task automatic send(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1; bus.s_bit = b;
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_valid(input int target, input int limit, input string tag);
        for (int i = 0; i < limit && valid_cnt < target; i++) tick();
        chk(tag, 64'(valid_cnt >= target), 64'd1);
    endtask

    initial begin
        bus.ce = 1'b1; bus.s_valid = 1'b0; bus.s_bit = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        bus8.ce = 1'b1; bus8.s_valid = 1'b0; bus8.s_bit = 1'b0;
        bus8.coef_we = 1'b0; bus8.coef_addr = '0; bus8.coef_data = '0;

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data), 64'd0);
        chk("rst_overrun",   64'(bus.overrun), 64'd0);
        chk("rst_mca_start", 64'(bus.mca_start), 64'd0);
        chk("rst_s_values",  64'(bus.mca_s_values), 64'd0);
        chk("rst_coef15",    64'(bus.mca_operands[15]), 64'd0);

        // Ramp coefficients, 16 ones -> 1+2+...+16
        prog_ramp();
        chk("coef0", 64'(bus.mca_operands[0]), 64'd1);
        chk("coef15", 64'(bus.mca_operands[15]), 64'd16);
        send(1'b1, 16);
        wait_valid(1, 60, "t1_timeout");
        chk("t1_starts", 64'(start_cnt), 64'd1);
        chk("t1_latency", 64'(valid_at - start_at), 64'd18);
        chk("t1_data", 64'(last_data), 64'd136);
        chk("t1_snapshot", 64'(bus.mca_s_values), 64'hFFFF);
        tick(); tick(); tick();
        chk("t1_hold_data", 64'(bus.out_data), 64'd136);
        chk("t1_valid_low", 64'(bus.out_valid), 64'd0);

        // Alternating bits, coefficients all 5 -> +5/-5 cancel
        do_reset();
        for (int k = 0; k < 16; k++) begin
            bus.coef_we = 1'b1; bus.coef_addr = 4'(k); bus.coef_data = W'(5);
            tick();
        end
        bus.coef_we = 1'b0;
        for (int i = 0; i < 16; i++) send(((i % 2) == 0), 1);
        wait_valid(1, 60, "t2_timeout");
        chk("t2_sval0", 64'(bus.mca_s_values[0]), 64'd0);
        chk("t2_snapshot", 64'(bus.mca_s_values), 64'hAAAA);
        chk("t2_data", 64'(last_data), 64'd0);
        tick();
        send(1'b1, 1); send(1'b0, 1); send(1'b1, 1);
        tick(); tick();
        chk("t2_no_early", 64'(start_cnt), 64'd1);
        send(1'b0, 1);
        wait_valid(2, 60, "t2_timeout2");
        chk("t2_starts", 64'(start_cnt), 64'd2);
        chk("t2_data2", 64'(last_data), 64'd0);
        chk("t2_overrun", 64'(bus.overrun), 64'd0);

        // Continuous samples: triggers every 4 samples while busy get dropped
        do_reset();
        prog_ramp();
        send(1'b1, 19);
        chk("t3_ovr_before", 64'(bus.overrun), 64'd0);
        send(1'b1, 1);
        chk("t3_ovr_after", 64'(bus.overrun), 64'd1);
        send(1'b1, 36);
        wait_valid(3, 60, "t3_timeout");
        tick(); tick();
        chk("t3_starts", 64'(start_cnt), 64'd3);
        chk("t3_valids", 64'(valid_cnt), 64'd3);
        chk("t3_sticky", 64'(bus.overrun), 64'd1);
        chk("t3_data", 64'(last_data), 64'd136);

        // ce toggling during the wait: 8 ones then 8 zeros -> 100-36
        do_reset();
        prog_ramp();
        send(1'b1, 8);
        send(1'b0, 8);
        for (int i = 0; i < 80 && valid_cnt == 0; i++) begin
            bus.ce = ((i % 2) == 0);
            tick();
        end
        bus.ce = 1'b1;
        chk("t4_latency", 64'(valid_at - start_at), 64'd18);
        chk("t4_data", 64'(last_data), 64'd64);
        chk("t4_snapshot", 64'(bus.mca_s_values), 64'hFF00);
        chk("t4_no_strobe_ce0", 64'(bad_cnt), 64'd0);
        bus.ce = 1'b0;
        #1;
        chk("t4_enable", 64'(bus.mca_enable), 64'd0);
        bus.ce = 1'b1;

        // Reset at wait count 8 abandons the computation
        do_reset();
        prog_ramp();
        send(1'b1, 16);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_data", 64'(bus.out_data), 64'd0);
        chk("t5_snapshot", 64'(bus.mca_s_values), 64'd0);
        chk("t5_coef15", 64'(bus.mca_operands[15]), 64'd0);
        chk("t5_start", 64'(bus.mca_start), 64'd0);
        for (int i = 0; i < 30; i++) tick();
        chk("t5_no_valid", 64'(valid_cnt), 64'd0);
        prog_ramp();
        send(1'b1, 15);
        tick(); tick(); tick();
        chk("t5_fresh_fill", 64'(start_cnt), 64'd0);
        send(1'b0, 1);
        wait_valid(1, 60, "t5_timeout");
        chk("t5_data2", 64'(last_data), 64'd134);
        chk("t5_snapshot2", 64'(bus.mca_s_values), 64'hFFFE);

        // Coefficient write coinciding with the trigger
        do_reset();
        prog_ramp();
        send(1'b1, 15);
        bus.s_valid = 1'b1; bus.s_bit = 1'b1;
        bus.coef_we = 1'b1; bus.coef_addr = 4'd15; bus.coef_data = W'(100);
        tick();
        bus.s_valid = 1'b0; bus.coef_we = 1'b0;
        chk("t6_coef15", 64'(bus.mca_operands[15]), 64'd100);
        wait_valid(1, 60, "t6_timeout");
        chk("t6_data", 64'(last_data), 64'd220);

        // 8-operand instance: writes to addresses 8..15 are ignored
        rst8 = 1'b1;
        tick(); tick();
        rst8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus8.coef_we = 1'b1; bus8.coef_addr = 4'(k); bus8.coef_data = W'(k + 1);
            tick();
        end
        bus8.coef_addr = 4'd15; bus8.coef_data = W'(999); tick();
        bus8.coef_addr = 4'd8;  bus8.coef_data = W'(777); tick();
        bus8.coef_we = 1'b0;
        chk("t7_coef7", 64'(bus8.mca_operands[7]), 64'd8);
        chk("t7_coef0", 64'(bus8.mca_operands[0]), 64'd1);
        for (int i = 0; i < 8; i++) begin
            bus8.s_valid = 1'b1; bus8.s_bit = 1'b1;
            bus8.coef_we = (i == 7); bus8.coef_addr = 4'd15; bus8.coef_data = W'(500);
            tick();
        end
        bus8.s_valid = 1'b0; bus8.coef_we = 1'b0;
        for (int i = 0; i < 60 && valid8_cnt == 0; i++) tick();
        chk("t7_valids", 64'(valid8_cnt), 64'd1);
        chk("t7_starts", 64'(start8_cnt), 64'd1);
        chk("t7_data", 64'(last8), 64'd36);
        chk("t7_coef7_after", 64'(bus8.mca_operands[7]), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
